// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the dcache/icache requesters, main memory and mem_bus_arbiter.
// The slave modport is the arbiter's view; master is the view of whoever drives the requests.
interface mem_bus_arbiter_if #(
  parameter int unsigned TAG_W = 4
);
  // requester side
  logic [1:0]       d_command;
  logic [31:0]      d_addr;
  logic [63:0]      d_data;
  logic [1:0]       i_command;
  logic [31:0]      i_addr;
  // memory side
  logic [1:0]       proc2mem_command;
  logic [31:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [TAG_W-1:0] mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_tag;
  // responses routed back to requesters
  logic [TAG_W-1:0] d_response;
  logic [TAG_W-1:0] i_response;
  logic [TAG_W-1:0] d_rsp_tag;
  logic [TAG_W-1:0] i_rsp_tag;
  logic [63:0]      rsp_data;
  logic             arb_err;

  modport slave (
    input  d_command, d_addr, d_data, i_command, i_addr,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output d_response, i_response, d_rsp_tag, i_rsp_tag, rsp_data, arb_err
  );

  modport master (
    output d_command, d_addr, d_data, i_command, i_addr,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  d_response, i_response, d_rsp_tag, i_rsp_tag, rsp_data, arb_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the main-memory port between dcache and icache.
// Grant and forwarding are combinational; hold state, tag-owner table and arb_err are registered.
// Optional feature: define MEM_ARB_STARVE_EN to add an icache anti-starvation counter
// (STARVE_LIMIT parameter exists only in that build).
module mem_bus_arbiter #(
  parameter int unsigned TAG_W = 4
`ifdef MEM_ARB_STARVE_EN
  , parameter int unsigned STARVE_LIMIT = 8
`endif
) (
  input  logic             clock,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned NTAG = 32'(1) << TAG_W;
  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD_D = 2'd1, S_HOLD_I = 2'd2} state_t;

  state_t state_q, state_d;

  logic            d_req, i_req, accepted, starve_hit;
  logic            gnt_d, gnt_i;
  logic            ret_hit, alloc;
  logic [NTAG-1:0] valid_q, valid_d;
  logic [NTAG-1:0] owner_q, owner_d;   // 1 = icache owns the tag
  logic            arb_err_q, arb_err_d;

  logic [1:0]       cmd;
  logic [31:0]      addr;
  logic [63:0]      data;
  logic [TAG_W-1:0] d_resp, i_resp, d_rtag, i_rtag;
  logic [63:0]      rdata;

  // icache STORE is illegal and never requests; reset masks all requests
  assign d_req    = !reset && (bus.d_command != CMD_NONE);
  assign i_req    = !reset && (bus.i_command == CMD_LOAD);
  assign accepted = (bus.mem2proc_response != '0);

`ifdef MEM_ARB_STARVE_EN
  logic [7:0] starve_q, starve_d;

  // count cycles icache wants the bus but loses; saturate rather than wrap
  always_comb begin
    starve_d = starve_q;
    if (gnt_i) begin
      starve_d = '0;
    end else if (i_req && (starve_q != 8'hFF)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // starve counter register
  always_ff @(posedge clock) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign starve_hit = (starve_q >= 8'(STARVE_LIMIT));
`else
  assign starve_hit = 1'b0;
`endif

  // arbitration: a held requester keeps the grant; otherwise arbitrate fresh
  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    if ((state_q == S_HOLD_D) && d_req) begin
      gnt_d = 1'b1;
    end else if ((state_q == S_HOLD_I) && i_req) begin
      gnt_i = 1'b1;
    end else if (starve_hit && i_req) begin
      gnt_i = 1'b1;
    end else if (d_req) begin
      gnt_d = 1'b1;
    end else if (i_req) begin
      gnt_i = 1'b1;
    end
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state: a rejected grant holds that requester
  always_comb begin
    state_d = S_IDLE;
    if (gnt_d && !accepted) begin
      state_d = S_HOLD_D;
    end else if (gnt_i && !accepted) begin
      state_d = S_HOLD_I;
    end
  end

  // forwarding and response routing outputs
  always_comb begin
    cmd    = CMD_NONE;
    addr   = '0;
    data   = '0;
    d_resp = '0;
    i_resp = '0;
    d_rtag = '0;
    i_rtag = '0;
    rdata  = '0;
    if (gnt_d) begin
      cmd    = bus.d_command;
      addr   = bus.d_addr;
      data   = bus.d_data;
      d_resp = bus.mem2proc_response;
    end else if (gnt_i) begin
      cmd    = bus.i_command;
      addr   = bus.i_addr;
      i_resp = bus.mem2proc_response;
    end
    if (ret_hit && valid_q[bus.mem2proc_tag]) begin
      if (owner_q[bus.mem2proc_tag]) i_rtag = bus.mem2proc_tag;
      else                           d_rtag = bus.mem2proc_tag;
    end
    if (!reset) rdata = bus.mem2proc_data;
  end

  assign ret_hit = !reset && (bus.mem2proc_tag != '0);
  assign alloc   = accepted && (gnt_i || (gnt_d && (bus.d_command == CMD_LOAD)));

  // owner table update: retire first so a same-tag allocate overrides it
  always_comb begin
    valid_d   = valid_q;
    owner_d   = owner_q;
    arb_err_d = arb_err_q;
    if (ret_hit) begin
      if (valid_q[bus.mem2proc_tag]) valid_d[bus.mem2proc_tag] = 1'b0;
      else                           arb_err_d = 1'b1;
    end
    if (alloc) begin
      valid_d[bus.mem2proc_response] = 1'b1;
      owner_d[bus.mem2proc_response] = gnt_i;
    end
  end

  // owner table and sticky error registers
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      owner_q   <= '0;
      arb_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      owner_q   <= owner_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign bus.proc2mem_command = cmd;
  assign bus.proc2mem_addr    = addr;
  assign bus.proc2mem_data    = data;
  assign bus.d_response       = d_resp;
  assign bus.i_response       = i_resp;
  assign bus.d_rsp_tag        = d_rtag;
  assign bus.i_rsp_tag        = i_rtag;
  assign bus.rsp_data         = rdata;
  assign bus.arb_err          = arb_err_q;

endmodule
